uncached_wr_buffer: RTL and testbench
=====================================

# uncached_wr_buffer

Posted-write buffer for uncached stores. It sits between the D$ uncached path (fed by `dcache_req_t` writes with `uncached=1`) and the AXI3 write channel. It queues up to DEPTH single-word stores and drains them in order as single-beat AXI3 write transactions, one outstanding at a time. It exposes `empty` and an address-match query so the D$ can order uncached reads behind pending stores.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `AXI_ID`, 0, constant value driven on `awid`/`wid`.
- `BUS_WIDTH`, 4, AXI id width; matches `axi3_wr_if`.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `push` input 1: enqueue request.
- `push_paddr` input 32: word-aligned physical address; bits [1:0] are ignored and driven 0 on AXI.
- `push_be` input 4: byte enables.
- `push_wrdata` input 32: store data.
- `push_ready` output 1: not full.
- `query_paddr` input 32: address checked for a pending store.
- `query_hit` output 1: combinational; some valid entry (including the in-flight head) has bits [31:2] equal to `query_paddr[31:2]`.
- `empty` output 1: no valid entries and FSM in IDLE.
- `axi` `axi3_wr_if.master`: AXI3 write master (`axi3_wr_req`, `awid`, `wid` out; `axi3_wr_resp`, `bid` in).

## Operation
- Entry = {paddr, be, wrdata}. Entries sit in a circular FIFO with `rd_ptr`, `wr_ptr` (log2 DEPTH bits, natural wrap) and `count` ($clog2(DEPTH+1) bits).
- Push is accepted when `push && push_ready`. A push while full is dropped; the D$ must hold the request until `push_ready` is high.
- The head entry stays in the FIFO until its B response. It is popped on `bvalid && bready`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. `push_ready` is computed from the current `count` only, so a pop does not free a slot in the same cycle.
- FSM states:
  - IDLE: if `count != 0`, go to SEND.
  - SEND: `awvalid` and `wvalid` are asserted, each until its own handshake. Sticky flags `aw_done` and `w_done` record completed handshakes; AW and W may complete in either order or together. When both are done (including the completing cycle), go to RESP and clear the flags.
  - RESP: `bready=1`. On `bvalid`, pop the head and go to IDLE.
- Fixed AXI fields:
  - `awlen=0`, `awsize=3'b010`, `awburst=2'b01`, `awlock=0`, `awcache=0`, `awprot=0`.
  - `wstrb=be`, `wlast=1`.
  - `awid=wid=AXI_ID`.
  - `awaddr`/`wdata` come from the head entry.
- `bresp` and `bid` are ignored.
- `query_hit` scans all DEPTH slots, gated by per-slot valid bits.

## Timing
- Reset (`rst_n=0` at an edge): pointers, `count`, valid bits and flags cleared; FSM to IDLE.
- Output values after reset:
  - `push_ready=1`, `empty=1`, `query_hit=0`.
  - `awvalid=wvalid=bready=0`.
- Reset mid-transaction abandons the in-flight write. The interconnect is reset together with this block.
- Latency on an idle buffer:
  - Push at edge T.
  - FSM enters SEND at T+1.
  - `awvalid`/`wvalid` are high in the cycle after edge T+1.
- Best-case per-store throughput: SEND 1 cycle, RESP ≥1 cycle, IDLE 1 cycle, so 3 cycles per store.
- `awvalid`/`wvalid` never drop before their handshake. Address and data are stable while valid.
- `empty` goes high in the cycle after the last pop edge.

## Structure
- `wb_entry_t` {`phys_t paddr; logic [3:0] be; uint32_t wrdata;`} belongs in `common_defs.svh`, next to `dcache_req_t`.
- Sub-module `wb_fifo`: storage, pointers, count, valid bits, and the parallel match for `query_hit`. Parameterised by DEPTH and the entry type.
- The top level holds the AXI FSM and the fixed-field assignment.

## Test plan
- Single store:
  - Stimulus: push {0x1FC0_0010, be=4'hF, 0xDEADBEEF}; slave ready always.
  - Required: one AW with awaddr=0x1FC0_0010, awlen=0; W with wdata=0xDEADBEEF, wstrb=4'hF, wlast=1. `empty` is 1 one cycle after B.
- Full FIFO:
  - Stimulus: 8 back-to-back pushes with `awready=0`.
  - Required: `push_ready=0` after the 8th. A 9th push held for 3 cycles is not enqueued. Raising `awready` drains the stores in push order; the 9th is accepted the cycle after the first pop.
- AW/W skew:
  - Stimulus: `wready` delayed 5 cycles relative to `awready`, then the reverse.
  - Required: exactly one AW and one W per store, no re-issue; `bready` only after both handshakes.
- Query:
  - Stimulus: pending store to 0x1FAF_F004; query 0x1FAF_F006.
  - Required: `query_hit=1`, and it stays 1 until the B handshake of that store; query 0x1FAF_F008 gives `query_hit=0`.
- Wrap and concurrency:
  - Stimulus: 20 stores with random slave stalls and pushes coinciding with pops.
  - Required: AXI order and data match push order; `count` never exceeds 8.
- Reset mid-SEND:
  - Stimulus: assert `rst_n=0` for 1 cycle with `awvalid` high.
  - Required: the next cycle shows `awvalid=0`, `empty=1`, `push_ready=1`.

Source files
------------

// File: rtl/uncached_wr_buffer_pkg.sv
// Shared types for the uncached posted-write buffer: FIFO entry, AXI3 write
// channel bundles and the drain FSM state encoding.
package uncached_wr_buffer_pkg;

  typedef logic [31:0] phys_t;
  typedef logic [31:0] uint32_t;

  typedef struct packed {
    phys_t      paddr;
    logic [3:0] be;
    uint32_t    wrdata;
  } wb_entry_t;

  typedef struct packed {
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } axi3_wr_req_t;

  typedef struct packed {
    logic       awready;
    logic       wready;
    logic [1:0] bresp;
    logic       bvalid;
  } axi3_wr_resp_t;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_SEND = 2'd1,
    WB_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/axi3_wr_if.sv
// AXI3 write-channel bundle (AW, W, B) with master/slave views.
interface axi3_wr_if
  import uncached_wr_buffer_pkg::*;
#(
  parameter int BUS_WIDTH = 4
) ();
  axi3_wr_req_t         axi3_wr_req;
  axi3_wr_resp_t        axi3_wr_resp;
  logic [BUS_WIDTH-1:0] awid;
  logic [BUS_WIDTH-1:0] wid;
  logic [BUS_WIDTH-1:0] bid;

  modport master (output axi3_wr_req, output awid, output wid,
                  input  axi3_wr_resp, input bid);
  modport slave  (input  axi3_wr_req, input awid, input wid,
                  output axi3_wr_resp, output bid);
endinterface

// File: rtl/wb_fifo.sv
// Circular store queue with per-slot valid bits and a parallel word-address
// match across every occupied slot, including the head still awaiting B.
module wb_fifo
  import uncached_wr_buffer_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  entry_t push_entry_i,
  input  logic   pop_i,
  input  phys_t  query_paddr_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o,
  output logic   query_hit_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] vld_q;
  entry_t           mem_q [DEPTH];
  logic             push_acc, pop_acc;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign push_acc = push_i && !full_o;
  assign pop_acc  = pop_i && !empty_o;
  assign head_o   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (push_acc) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push_acc) - CW'(pop_acc);
    end
  end

  // Payload needs no reset; the valid bits qualify every read of it.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_comb begin
    query_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (mem_q[i].paddr[31:2] == query_paddr_i[31:2])) query_hit_o = 1'b1;
    end
  end

  logic unused_query_lsb;
  assign unused_query_lsb = ^query_paddr_i[1:0];

endmodule

// File: rtl/uncached_wr_buffer.sv
// Posted-write buffer for uncached stores: queues single-word stores and
// drains them in order as single-beat AXI3 writes, one outstanding at a time.
module uncached_wr_buffer
  import uncached_wr_buffer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AXI_ID    = 0,
  parameter int BUS_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_paddr,
  input  logic [3:0]  push_be,
  input  logic [31:0] push_wrdata,
  output logic        push_ready,
  input  logic [31:0] query_paddr,
  output logic        query_hit,
  output logic        empty,
  axi3_wr_if.master   axi
);
  wb_state_e    state_q, state_d;
  logic         aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic         fifo_full, fifo_empty, pop;
  wb_entry_t    push_entry, head;
  axi3_wr_req_t req;
  logic         aw_fin, w_fin;

  assign push_entry = '{paddr: push_paddr, be: push_be, wrdata: push_wrdata};

  wb_fifo #(.DEPTH(DEPTH), .entry_t(wb_entry_t)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .query_paddr_i(query_paddr),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head),
    .query_hit_o  (query_hit)
  );

  assign push_ready = !fifo_full;
  assign empty      = fifo_empty && (state_q == WB_IDLE);
  assign pop        = (state_q == WB_RESP) && axi.axi3_wr_resp.bvalid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= WB_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    req         = '0;
    req.awaddr  = {head.paddr[31:2], 2'b00};
    req.awsize  = 3'b010;
    req.awburst = 2'b01;
    req.wdata   = head.wrdata;
    req.wstrb   = head.be;
    req.wlast   = 1'b1;
    aw_fin      = 1'b0;
    w_fin       = 1'b0;
    case (state_q)
      WB_IDLE: if (!fifo_empty) state_d = WB_SEND;
      WB_SEND: begin
        req.awvalid = !aw_done_q;
        req.wvalid  = !w_done_q;
        // A handshake completing this cycle counts as done.
        aw_fin = aw_done_q || axi.axi3_wr_resp.awready;
        w_fin  = w_done_q  || axi.axi3_wr_resp.wready;
        if (aw_fin && w_fin) begin
          state_d   = WB_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      WB_RESP: begin
        req.bready = 1'b1;
        if (axi.axi3_wr_resp.bvalid) state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign axi.axi3_wr_req = req;
  assign axi.awid        = BUS_WIDTH'(AXI_ID);
  assign axi.wid         = BUS_WIDTH'(AXI_ID);

  logic unused_axi;
  assign unused_axi = ^{axi.axi3_wr_resp.bresp, axi.bid, head.paddr[1:0]};

endmodule

// File: tb/tb_uncached_wr_buffer.sv
// Scoreboarded bench: accepted pushes queue expected AXI writes; a negedge
// monitor checks each AW/W/B against the queue head in push order.
module tb_uncached_wr_buffer;
  import uncached_wr_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic [31:0] push_paddr = '0;
  logic [3:0]  push_be = '0;
  logic [31:0] push_wrdata = '0;
  logic        push_ready, query_hit, empty;
  logic [31:0] query_paddr = '0;

  logic          aw_rdy_f = 1'b1, w_rdy_f = 1'b1, rnd = 1'b0;
  axi3_wr_resp_t s_resp = '0;
  axi3_wr_req_t  rq;

  axi3_wr_if #(.BUS_WIDTH(4)) axi_if ();
  assign axi_if.axi3_wr_resp = s_resp;
  assign axi_if.bid          = 4'd0;
  assign rq                  = axi_if.axi3_wr_req;

  uncached_wr_buffer #(.DEPTH(8), .AXI_ID(0), .BUS_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_paddr(push_paddr),
    .push_be(push_be), .push_wrdata(push_wrdata), .push_ready(push_ready),
    .query_paddr(query_paddr), .query_hit(query_hit), .empty(empty),
    .axi(axi_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_aw = 0, n_w = 0, n_b = 0;
  logic m_aw = 1'b0, m_w = 1'b0, b_pend = 1'b0;
  wb_entry_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Slave: ready generation and a single B per completed AW+W pair.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      s_resp = '0;
      b_pend = 1'b0;
    end else begin
      s_resp.awready = rnd ? 1'($urandom_range(0, 1)) : aw_rdy_f;
      s_resp.wready  = rnd ? 1'($urandom_range(0, 1)) : w_rdy_f;
      if (b_pend) begin
        s_resp.bvalid = 1'b0;
        b_pend = 1'b0;
      end else if (m_aw && m_w && !s_resp.bvalid && (!rnd || $urandom_range(0, 2) != 0))
        s_resp.bvalid = 1'b1;
    end
  end

  // Monitor: a handshake seen at negedge completes at the following posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_aw = 1'b0;
      m_w  = 1'b0;
    end else begin
      if (rq.bready) chk("bready_after_aw_w", 32'(m_aw && m_w), 32'd1);
      if (rq.awvalid && s_resp.awready) begin
        if (exp_q.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
        else begin
          chk("awaddr", rq.awaddr, {exp_q[0].paddr[31:2], 2'b00});
          chk("aw_fixed", {rq.awlen, 1'b0, rq.awsize, 2'b0, rq.awburst, rq.awlock, rq.awcache, 1'b0, rq.awprot},
              {4'd0, 1'b0, 3'b010, 2'b0, 2'b01, 2'b00, 4'd0, 1'b0, 3'd0});
          chk("awid", 32'(axi_if.awid), 32'd0);
          chk("aw_once", 32'(m_aw), 32'd0);
        end
        m_aw = 1'b1;
        n_aw++;
      end
      if (rq.wvalid && s_resp.wready) begin
        if (exp_q.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
        else begin
          chk("wdata", rq.wdata, exp_q[0].wrdata);
          chk("wstrb_wlast", {27'd0, rq.wlast, rq.wstrb}, {27'd0, 1'b1, exp_q[0].be});
          chk("wid", 32'(axi_if.wid), 32'd0);
          chk("w_once", 32'(m_w), 32'd0);
        end
        m_w = 1'b1;
        n_w++;
      end
      if (rq.bready && s_resp.bvalid) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        m_aw = 1'b0;
        m_w  = 1'b0;
        b_pend = 1'b1;
        n_b++;
      end
    end
  end

  task automatic do_push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    wb_entry_t e;
    bit acc = 0;
    push = 1'b1; push_paddr = a; push_be = be; push_wrdata = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (push_ready) begin
        e.paddr = a; e.be = be; e.wrdata = d;
        exp_q.push_back(e);
        chk("occupancy_le_8", 32'(exp_q.size() <= 8), 32'd1);
        acc = 1;
        break;
      end
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
    tick();
    push = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (empty && exp_q.size() == 0) begin ok = 1; break; end
    end
    chk("drain_done", 32'(ok), 32'd1);
    tick();
  endtask

  task automatic wait_b();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rq.bready && s_resp.bvalid) begin ok = 1; break; end
    end
    chk("b_seen", 32'(ok), 32'd1);
  endtask

  int aw0, w0, b0;

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_query_hit", 32'(query_hit), 32'd0);
    chk("rst_valids", {29'd0, rq.awvalid, rq.wvalid, rq.bready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single store, latency and empty after B
    aw0 = n_aw; w0 = n_w;
    do_push(32'h1FC0_0010, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lat_idle_awvalid", 32'(rq.awvalid), 32'd0);
    @(negedge clk);
    chk("lat_send_valids", {30'd0, rq.awvalid, rq.wvalid}, 32'd3);
    wait_b();
    chk("empty_during_b", 32'(empty), 32'd0);
    @(negedge clk);
    chk("empty_after_b", 32'(empty), 32'd1);
    chk("single_aw_w", {16'(n_aw - aw0), 16'(n_w - w0)}, {16'd1, 16'd1});
    tick();

    // Full FIFO with AW stalled, 9th push held off
    aw_rdy_f = 1'b0;
    b0 = n_b;
    for (int i = 0; i < 8; i++) do_push(32'h1000_0000 + 32'(i) * 4, 4'(i + 1), 32'hA500_0000 + 32'(i));
    @(negedge clk);
    chk("full_push_ready", 32'(push_ready), 32'd0);
    push = 1'b1; push_paddr = 32'h1000_0100; push_be = 4'h3; push_wrdata = 32'h0000_9999;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("ninth_blocked", 32'(push_ready), 32'd0);
    end
    tick();
    aw_rdy_f = 1'b1;
    wait_b();
    chk("ninth_blocked_at_pop", 32'(push_ready), 32'd0);
    @(negedge clk);
    chk("ninth_ready_after_pop", 32'(push_ready), 32'd1);
    begin
      wb_entry_t e;
      e.paddr = 32'h1000_0100; e.be = 4'h3; e.wrdata = 32'h0000_9999;
      exp_q.push_back(e);
    end
    tick();
    push = 1'b0;
    wait_drain();
    chk("full_b_count", 32'(n_b - b0), 32'd9);

    // AW/W skew both ways
    aw0 = n_aw; w0 = n_w;
    w_rdy_f = 1'b0;
    do_push(32'h3000_0040, 4'h5, 32'h1234_5678);
    repeat (5) @(negedge clk);
    chk("skew_aw_held_low", {30'd0, rq.awvalid, rq.wvalid}, 32'd1);
    tick();
    w_rdy_f = 1'b1;
    wait_drain();
    aw_rdy_f = 1'b0;
    do_push(32'h3000_0044, 4'hA, 32'h8765_4321);
    repeat (5) @(negedge clk);
    chk("skew_w_held_low", {30'd0, rq.awvalid, rq.wvalid}, 32'd2);
    tick();
    aw_rdy_f = 1'b1;
    wait_drain();
    chk("skew_aw_w_count", {16'(n_aw - aw0), 16'(n_w - w0)}, {16'd2, 16'd2});

    // Query hit over the life of a pending store
    aw_rdy_f = 1'b0;
    query_paddr = 32'h1FAF_F006;
    do_push(32'h1FAF_F004, 4'hF, 32'h0BAD_F00D);
    @(negedge clk);
    chk("query_hit_pending", 32'(query_hit), 32'd1);
    tick();
    query_paddr = 32'h1FAF_F008;
    @(negedge clk);
    chk("query_miss_next_word", 32'(query_hit), 32'd0);
    tick();
    query_paddr = 32'h1FAF_F006;
    aw_rdy_f = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        chk("query_hold_until_b", 32'(query_hit), 32'd1);
        if (rq.bready && s_resp.bvalid) begin ok = 1; break; end
      end
      chk("query_b_seen", 32'(ok), 32'd1);
    end
    @(negedge clk);
    chk("query_clear_after_b", 32'(query_hit), 32'd0);
    wait_drain();

    // Wrap and concurrency with random slave stalls
    rnd = 1'b1;
    b0 = n_b;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      do_push(32'h2000_0000 + 32'(i) * 4 + 32'($urandom_range(0, 3)),
              4'($urandom_range(1, 15)), $urandom);
    end
    wait_drain();
    rnd = 1'b0;
    chk("wrap_b_count", 32'(n_b - b0), 32'd20);

    // Reset while in SEND
    aw_rdy_f = 1'b0;
    query_paddr = 32'h4000_0000;
    do_push(32'h4000_0000, 4'hF, 32'hCAFE_0001);
    begin
      bit ok = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (rq.awvalid) begin ok = 1; break; end
      end
      chk("mid_send_awvalid", 32'(ok), 32'd1);
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_awvalid", 32'(rq.awvalid), 32'd0);
    chk("post_rst_empty_ready", {30'd0, empty, push_ready}, 32'd3);
    chk("post_rst_query", 32'(query_hit), 32'd0);
    tick();
    aw_rdy_f = 1'b1;
    do_push(32'h4000_0008, 4'hC, 32'hCAFE_0002);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
